// File: rtl/spi_slave_frontend.sv
// -----------------------------------------------------------------------------
// spi_slave_frontend
//
// SPI mode-0 slave front end that runs entirely in the FPGA clk domain. It
// oversamples the asynchronous SPI pins and splits each SSEL-framed transfer
// into one command byte (byte 0) and any number of parameter bytes. It also
// shifts the interpreter's response byte back out on MISO.
//
// Optional feature (compile-time macro SPI_IDLE_TIMEOUT_EN):
//   When the macro is defined, a frame aborts after TIMEOUT_CYCLES clk cycles
//   with SSEL low and no SCK edge. When it is not defined, a frame ends only
//   when SSEL rises.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth for sck/mosi/ssel (minimum 2)
//   TIMEOUT_CYCLES  idle abort threshold (used only with SPI_IDLE_TIMEOUT_EN)
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   sck/mosi/ssel  asynchronous SPI pins (mode 0, MSB first, ssel active low)
//   miso, miso_oe  serial response and its output enable
//   cmd_ready      one-cycle strobe when byte 0 of a frame completes
//   param_ready    one-cycle strobe when byte 1 or a later byte completes
//   cmd_data       last command byte; held across frames
//   param_data     last parameter byte
//   byte_cnt       bytes completed in the current frame; saturates
//   bit_cnt        bits sampled in the current byte
//   spi_data_in    response byte, loaded at each byte boundary
//   frame_active   high while a frame is in progress
//   frame_end      one-cycle strobe when a frame ends or aborts
// -----------------------------------------------------------------------------
module spi_slave_frontend #(
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sck,
   input  logic        mosi,
   input  logic        ssel,
   output logic        miso,
   output logic        miso_oe,
   output logic        cmd_ready,
   output logic        param_ready,
   output logic [7:0]  cmd_data,
   output logic [7:0]  param_data,
   output logic [31:0] byte_cnt,
   output logic [2:0]  bit_cnt,
   input  logic [7:0]  spi_data_in,
   output logic        frame_active,
   output logic        frame_end
);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_PARAM} state_t;

   // ---------------------------------------------------------------------
   // Synchronisers. Index 0 is sck, index 1 is mosi, index 2 is ssel.
   // Each pin passes through SYNC_STAGES flops and then one history flop.
   // ---------------------------------------------------------------------
   logic [2:0] pins;
   logic [2:0] sync_s;
   logic [2:0] prev_s;

   assign pins = {ssel, mosi, sck};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;
         logic                   hist_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               chain_reg <= '0;
               hist_reg  <= 1'b0;
            end else begin
               chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
               hist_reg  <= chain_reg[SYNC_STAGES-1];
            end
         end
         assign sync_s[gi] = chain_reg[SYNC_STAGES-1];
         assign prev_s[gi] = hist_reg;
      end
   endgenerate

   // The synchronisers reset to 0. After a reset with SSEL held low, no fall
   // can be seen until SSEL has gone high and then low again.
   logic sck_rise, sck_fall, ssel_rise, ssel_fall, mosi_bit;
   assign sck_rise  =  sync_s[0] & ~prev_s[0];
   assign sck_fall  = ~sync_s[0] &  prev_s[0];
   assign ssel_rise =  sync_s[2] & ~prev_s[2];
   assign ssel_fall = ~sync_s[2] &  prev_s[2];
   // The MOSI bit is taken from its history flop. That flop has the same
   // delay as the SCK history flop, so the bit lines up with the pin time of
   // the SCK rise.
   assign mosi_bit  = prev_s[1];

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t      state_reg, state_next;
   logic [6:0]  rx_reg, rx_next;          // holds the partial byte (7 MSBs)
   logic [7:0]  tx_reg, tx_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [31:0] byte_cnt_reg, byte_cnt_next;
   logic [7:0]  cmd_data_reg, cmd_data_next;
   logic [7:0]  param_data_reg, param_data_next;
   logic        cmd_ready_reg, cmd_ready_next;
   logic        param_ready_reg, param_ready_next;
   logic        frame_active_reg, frame_active_next;
   logic        miso_oe_reg, miso_oe_next;
   logic        frame_end_reg, frame_end_next;
   logic        timeout_hit;

`ifdef SPI_IDLE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

   assign timeout_hit = (state_reg != ST_IDLE) && (idle_cnt_reg == TW'(TIMEOUT_CYCLES));

   always_comb begin
      idle_cnt_next = idle_cnt_reg;
      if (state_reg == ST_IDLE || sck_rise || sck_fall)
         idle_cnt_next = '0;
      else if (!timeout_hit)
         idle_cnt_next = idle_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) idle_cnt_reg <= '0;
      else     idle_cnt_reg <= idle_cnt_next;
   end
`else
   // No idle counter is built. The expression below is never true; it only
   // keeps TIMEOUT_CYCLES referenced in this build.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next        = state_reg;
      rx_next           = rx_reg;
      tx_next           = tx_reg;
      bit_cnt_next      = bit_cnt_reg;
      byte_cnt_next     = byte_cnt_reg;
      cmd_data_next     = cmd_data_reg;
      param_data_next   = param_data_reg;
      cmd_ready_next    = 1'b0;
      param_ready_next  = 1'b0;
      frame_active_next = frame_active_reg;
      miso_oe_next      = miso_oe_reg;
      frame_end_next    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // Any SCK edge in this cycle is ignored.
            if (ssel_fall) begin
               state_next        = ST_CMD;
               byte_cnt_next     = '0;
               bit_cnt_next      = '0;
               rx_next           = '0;
               tx_next           = spi_data_in;
               frame_active_next = 1'b1;
               miso_oe_next      = 1'b1;
            end
         end
         ST_CMD, ST_PARAM: begin
            if (ssel_rise || timeout_hit) begin
               // SSEL rise takes priority over an SCK edge in the same cycle.
               // Any partial byte is dropped.
               state_next        = ST_IDLE;
               bit_cnt_next      = '0;
               rx_next           = '0;
               frame_active_next = 1'b0;
               miso_oe_next      = 1'b0;
               frame_end_next    = 1'b1;
            end else if (sck_rise) begin
               rx_next      = {rx_reg[5:0], mosi_bit};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  if (state_reg == ST_CMD) begin
                     cmd_data_next  = {rx_reg, mosi_bit};
                     byte_cnt_next  = 32'd1;
                     cmd_ready_next = 1'b1;
                     state_next     = ST_PARAM;
                  end else begin
                     param_data_next  = {rx_reg, mosi_bit};
                     param_ready_next = 1'b1;
                     if (byte_cnt_reg != 32'hFFFF_FFFF)
                        byte_cnt_next = byte_cnt_reg + 32'd1;
                  end
               end
            end else if (sck_fall) begin
               // bit_cnt is 0 on the fall that follows a completed byte. The
               // response for the next byte is loaded on that fall.
               if (bit_cnt_reg == 3'd0) tx_next = spi_data_in;
               else                     tx_next = {tx_reg[6:0], 1'b0};
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         rx_reg           <= '0;
         tx_reg           <= '0;
         bit_cnt_reg      <= '0;
         byte_cnt_reg     <= '0;
         cmd_data_reg     <= '0;
         param_data_reg   <= '0;
         cmd_ready_reg    <= 1'b0;
         param_ready_reg  <= 1'b0;
         frame_active_reg <= 1'b0;
         miso_oe_reg      <= 1'b0;
         frame_end_reg    <= 1'b0;
      end else begin
         state_reg        <= state_next;
         rx_reg           <= rx_next;
         tx_reg           <= tx_next;
         bit_cnt_reg      <= bit_cnt_next;
         byte_cnt_reg     <= byte_cnt_next;
         cmd_data_reg     <= cmd_data_next;
         param_data_reg   <= param_data_next;
         cmd_ready_reg    <= cmd_ready_next;
         param_ready_reg  <= param_ready_next;
         frame_active_reg <= frame_active_next;
         miso_oe_reg      <= miso_oe_next;
         frame_end_reg    <= frame_end_next;
      end
   end

   assign miso         = miso_oe_reg & tx_reg[7];
   assign miso_oe      = miso_oe_reg;
   assign cmd_ready    = cmd_ready_reg;
   assign param_ready  = param_ready_reg;
   assign cmd_data     = cmd_data_reg;
   assign param_data   = param_data_reg;
   assign byte_cnt     = byte_cnt_reg;
   assign bit_cnt      = bit_cnt_reg;
   assign frame_active = frame_active_reg;
   assign frame_end    = frame_end_reg;

endmodule
